// File: rtl/bundle_seq.sv
// Sequencer for the per-dimension bipolar vote counter: clears it, issues the
// programmed store beats from participating cores, then returns the majority sign.
module bundle_seq #(
    parameter int CORENUM = 32,
    parameter int W       = 30,
    parameter int LAT     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W-1:0]       num_items,
    input  logic [CORENUM-1:0] core_mask,
    input  logic               item_valid,
    output logic               item_ready,
    output logic               cnt_clr,
    output logic               store_flag,
    output logic [CORENUM-1:0] store,
    input  logic               sign_bit,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_bit,
    output logic               busy,
    output logic               done
);

    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       remaining_q, remaining_d;
    logic [CORENUM-1:0] mask_q, mask_d;
    logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
    logic               res_bit_q, res_bit_d;
    logic               res_valid_q, res_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            mask_q      <= '0;
            drain_cnt_q <= '0;
            res_bit_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            mask_q      <= mask_d;
            drain_cnt_q <= drain_cnt_d;
            res_bit_q   <= res_bit_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        mask_d      = mask_q;
        drain_cnt_d = drain_cnt_q;
        res_bit_d   = res_bit_q;
        res_valid_d = res_valid_q;
        cnt_clr     = 1'b0;
        item_ready  = 1'b0;
        store_flag  = 1'b0;
        store       = '0;
        done        = 1'b0;
        busy        = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (start) begin
                    remaining_d = num_items;
                    mask_d      = core_mask;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_clr = 1'b1;
                if (remaining_q == '0) begin
                    // Empty job still waits the full drain so the capture
                    // path is identical to a normal job.
                    drain_cnt_d = DW'(LAT - 1);
                    state_d     = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                item_ready = 1'b1;
                if (item_valid) begin
                    store_flag  = 1'b1;
                    store       = mask_q;
                    remaining_d = remaining_q - W'(1);
                    if (remaining_q == W'(1)) begin
                        drain_cnt_d = DW'(LAT - 1);
                        state_d     = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    res_bit_d   = sign_bit;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    done        = 1'b1;
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign res_bit   = res_bit_q;
    assign res_valid = res_valid_q;

endmodule

// File: doc/bundle_seq.md
# bundle_seq

Sequencer for the per-dimension bipolar vote counter in the HPU bundling datapath. It clears the counter before each job and issues a programmed number of store beats from participating cores, gated by an upstream valid/ready handshake. After the counter pipeline drains, it captures the counter's sign bit as the majority result and returns it through a valid/ready output handshake. It sits between the core array and the counter instance and owns the counter's `rst`, `store_flag` and `store` inputs.

## Interface
- `CORENUM`, 32: number of cores; width of `core_mask` and `store`.
- `W`, 30: width of the item count; matches the counter's accumulator width.
- `LAT`, 4: drain cycles between the last store beat and sign-bit capture. Must be ≥ the counter's store-to-`box` latency of 3.

- `clk` in 1: clock; every register samples on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: job request; sampled only in IDLE.
- `num_items` in W: number of store beats in the job; sampled with `start`.
- `core_mask` in CORENUM: participating cores; sampled with `start`.
- `item_valid` in 1: core results for the current beat are present.
- `item_ready` out 1: the controller accepts a beat this cycle.
- `cnt_clr` out 1: drives counter `rst`.
- `store_flag` out 1: drives counter `store_flag`.
- `store` out CORENUM: drives counter `store`.
- `sign_bit` in 1: counter `sign_bit`.
- `res_valid` out 1: the result is held.
- `res_ready` in 1: downstream accepts the result.
- `res_bit` out 1: the majority sign (1 = negative sum).
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the result is consumed.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, HOLD.
- IDLE
  - `cnt_clr`=1.
  - On `start`=1: latch `num_items` into `remaining` and `core_mask` into `mask_q`, then go to CLEAR.
- CLEAR: one cycle with `cnt_clr`=1. Go to RUN, or to DRAIN if `remaining`==0.
- RUN
  - `cnt_clr`=0 and `item_ready`=1.
  - A beat occurs when `item_valid` & `item_ready`.
  - On a beat: `store_flag`=1, `store`=`mask_q`, and `remaining` decrements.
  - With no beat: `store_flag`=0 and `store`=0.
  - A beat with `remaining`==1 moves the state to DRAIN and loads `drain_cnt`=LAT−1.
- DRAIN
  - `cnt_clr`=0, `item_ready`=0, `store_flag`=0, `store`=0.
  - `drain_cnt` decrements each cycle.
  - At `drain_cnt`==0: register `res_bit`<=`sign_bit`, set `res_valid`=1, go to HOLD.
- HOLD
  - `res_valid`=1 and `res_bit` is stable.
  - On `res_ready`=1: `done`=1 for that cycle, then go to IDLE. `res_valid` drops on the next cycle.
- `start` outside IDLE is ignored. A new `start` is accepted at the earliest in the cycle after the return to IDLE.
- `num_items`=0: the job runs CLEAR→DRAIN→HOLD and returns `res_bit`=0, because the cleared counter holds 0.
- `core_mask`=0: beats are still consumed, `store` stays 0, and the result is 0.
- `remaining` is a W-bit down-counter and does not wrap, since RUN exits at 1.

## Timing
- Reset (asynchronous): state=IDLE, `cnt_clr`=1, `item_ready`=0, `store_flag`=0, `store`=0, `res_valid`=0, `res_bit`=0, `busy`=0, `done`=0, `remaining`=0, `drain_cnt`=0.
- Reset mid-job aborts immediately and leaves the counter cleared. Partial votes are discarded.
- `item_ready`, `store_flag`, `store`, `cnt_clr`, `busy` and `done` are combinational from state and inputs. `res_bit` and `res_valid` are registered.
- Latency: `start` edge → first accept possible 2 cycles later (IDLE→CLEAR→RUN).
- Last beat → `res_valid` high after LAT+1 edges.
- Minimum job length: N beats → 2+N+LAT+1 cycles to `res_valid`, plus the handshake cycle.
- Gaps in `item_valid` stall RUN with no counter update.
- Simultaneous `res_valid` & `res_ready` in the first HOLD cycle completes in that cycle.

## Test plan
- Reset mid-RUN after 2 of 5 beats → `cnt_clr`=1, outputs at reset values, IDLE.
  - A following job with 3 beats, all cores +1, returns `res_bit`=0.
- `num_items`=4, `core_mask`=0x3, `item_valid` constant 1, cores vote +1 each beat.
  - `store`=0x3 on exactly 4 cycles.
  - `res_valid` rises 5 cycles after the 4th beat with `res_bit`=0.
  - `done` pulses once when `res_ready`=1.
- `num_items`=3, `core_mask`=0x1, votes −1, −1, +1, `item_valid` toggling 1,0,1,0,1 → 3 store beats only, `res_bit`=1.
- `num_items`=0 → no `store_flag`, `res_bit`=0.
  - `start` pulses during the job have no effect.
- `res_ready` held 0 for 10 cycles in HOLD → `res_valid`/`res_bit` stable, `busy`=1.
  - `done` pulses on the cycle `res_ready` rises.
